// File: rtl/instr_mem_loader_pkg.sv
// Shared types and frame constants for the instruction memory loader.
// The CHECK state only exists when INSTR_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        S_CHECK
`endif
    } state_e;

    function automatic int loader_depth(input int addr_w);
        return (2 ** addr_w) / WORD_BYTES;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter and full flag.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [2:0]  o_count,
    output logic        o_full
);
    logic [31:0] r_word;
    logic [2:0]  r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= {r_word[23:0], i_byte};
            r_count <= r_count + 3'd1;
        end
    end

    assign o_word  = r_word;
    assign o_count = r_count;
    assign o_full  = (r_count == 3'(WORD_BYTES));
endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: takes a length-prefixed byte stream and writes it word by word into instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              start,
    instr_mem_loader_if.slave bus,
    output logic              pipe_hold,
    output logic              done,
    output logic              error
);
    // state    | meaning
    // LEN_HI   | waiting for word count high byte
    // LEN_LO   | waiting for word count low byte, range check
    // DATA     | shifting data bytes into the word register
    // WRITE    | one-cycle memory write of the assembled word
    // CHECK    | waiting for the checksum byte (checksum build only)
    // DONE     | image loaded, pipeline released
    // ERR      | load aborted, pipeline held

    localparam int          DEPTH   = loader_depth(ADDR_W);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e S_FINAL = S_CHECK;
    logic [7:0] r_csum;
`else
    localparam state_e S_FINAL = S_DONE;
`endif

    state_e            r_state;
    state_e            w_next;
    logic [15:0]       r_len;
    logic [ADDR_W-2:0] r_k;
    logic              w_ready;
    logic              w_accept;
    logic              w_ld;
    logic              w_clr;
    logic              w_restart;
    logic              w_last_word;
    logic [15:0]       w_len_full;
    logic [31:0]       w_word;
    logic [2:0]        w_cnt;
    logic              w_full;

    assign w_accept    = bus.in_valid & w_ready;
    assign w_restart   = ((r_state == S_DONE) || (r_state == S_ERR)) && start;
    assign w_len_full  = {r_len[15:8], bus.in_data};
    assign w_last_word = (16'(r_k) + 16'd1) == r_len;

    word_assembler u_asm (
        .clk     (Clk),
        .rst_n   (Clr_n),
        .i_load  (w_ld),
        .i_clr   (w_clr),
        .i_byte  (bus.in_data),
        .o_word  (w_word),
        .o_count (w_cnt),
        .o_full  (w_full)
    );

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_ld    = 1'b0;
        w_clr   = 1'b0;
        unique case (r_state)
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    if ({1'b0, w_len_full} > DEPTH_W) w_next = S_ERR;
                    else if (w_len_full == 16'd0)     w_next = S_FINAL;
                    else                              w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_ld = 1'b1;
                    if (w_cnt == 3'(WORD_BYTES - 1)) w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_clr  = 1'b1;
                w_next = w_last_word ? S_FINAL : S_DATA;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready = 1'b1;
                if (w_accept) w_next = ((r_csum ^ bus.in_data) == 8'd0) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = S_LEN_HI;
                end
            end
            default: w_next = S_ERR;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state <= S_LEN_HI;
            r_len   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_len <= '0;
                r_k   <= '0;
            end else begin
                if (r_state == S_LEN_HI && w_accept) r_len[15:8] <= bus.in_data;
                if (r_state == S_LEN_LO && w_accept) r_len[7:0]  <= bus.in_data;
                if (r_state == S_WRITE)              r_k         <= r_k + (ADDR_W-1)'(1);
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Length bytes are part of the checksum too.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n)         r_csum <= '0;
        else if (w_restart) r_csum <= '0;
        else if (w_accept)  r_csum <= r_csum ^ bus.in_data;
    end
`endif

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = (r_state == S_WRITE) && w_full;
    assign bus.mem_addr  = {r_k[ADDR_W-3:0], 2'b00};
    assign bus.mem_wdata = w_word;
    assign done          = (r_state == S_DONE);
    assign error         = (r_state == S_ERR);
    assign pipe_hold     = (r_state != S_DONE);
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: vector table, randomized frames, reset/start corner cases.
module tb_instr_mem_loader;
    import loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = loader_depth(ADDR_W);
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Clr_n, start, pipe_hold, done, error;

    always #5 Clk = ~Clk;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Clr_n     (Clr_n),
        .start     (start),
        .bus       (bus),
        .pipe_hold (pipe_hold),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int n;
        int vmode;
        bit bad;
        int wsel;
        bit exp_ok;
        int exp_nw;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wbuf [0:127];
    logic [7:0]  frame [$];
    wr_t         wq [$];
    vec_t        vecs [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ok(input int n, input bit bad);
        return (n <= DEPTH) && !(CSUM_ON && bad);
    endfunction

    task automatic fill_words(input int n, input int wsel);
        for (int i = 0; i < 128; i++) wbuf[i] = $urandom;
        if (wsel == 1) begin
            wbuf[0] = 32'hE3A00001;
            wbuf[1] = 32'hE2811004;
        end else if (wsel == 2) begin
            wbuf[0] = 32'h01020304;
        end
        if (n < 0) wbuf[0] = 32'h0;
    endtask

    task automatic build_frame(input int n, input bit bad);
        logic [15:0] n16;
        logic [7:0]  cs;
        frame.delete();
        n16 = 16'(n);
        frame.push_back(n16[15:8]);
        frame.push_back(n16[7:0]);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++)
                for (int b = 0; b < WORD_BYTES; b++)
                    frame.push_back(wbuf[i][31-8*b -: 8]);
            cs = 8'h00;
            foreach (frame[i]) cs = cs ^ frame[i];
            if (bad) cs = cs ^ 8'h03;
            if (CSUM_ON) frame.push_back(cs);
        end
    endtask

    // Drives the queued frame; the strobe must follow every 4th data byte by exactly one cycle.
    task automatic run_frame(input int n, input int vmode, input int budget, output int cyc);
        int idx;
        bit exp_we;
        bit v;
        idx = 0; exp_we = 1'b0; cyc = 0;
        wq.delete();
        while ((idx < frame.size() || exp_we) && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            chk("we_timing", bus.mem_we, exp_we);
            chk("hold_loading", pipe_hold, 1);
            if (bus.mem_we) wq.push_back('{bus.mem_addr, bus.mem_wdata});
            exp_we = 1'b0;
            if (idx < frame.size()) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = 1'((cyc & 1) != 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.in_valid = v;
                bus.in_data  = frame[idx];
                if (v && bus.in_ready) begin
                    if (idx >= HDR_BYTES && idx < HDR_BYTES + WORD_BYTES * n &&
                        ((idx - HDR_BYTES) % WORD_BYTES) == WORD_BYTES - 1)
                        exp_we = 1'b1;
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        chk("timeout", cyc < budget, 1);
        @(negedge Clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic final_check(input bit exp_ok, input int nw);
        chk("done", done, exp_ok);
        chk("error", error, !exp_ok);
        chk("pipe_hold_end", pipe_hold, !exp_ok);
        chk("ready_end", bus.in_ready, 0);
        chk("n_writes", wq.size(), nw);
        for (int i = 0; i < wq.size() && i < nw; i++) begin
            chk("wr_addr", wq[i].addr, 4 * i);
            chk("wr_data", wq[i].data, wbuf[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_hold", pipe_hold, 1);
        chk("restart_ready", bus.in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.in_ready, 1);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_hold"}, pipe_hold, 1);
    endtask

    initial begin
        int cyc, cyc_first;
        Clr_n = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        cyc_first = 0;

        vecs.push_back('{2,  0, 1'b0, 1, 1'b1, 2});
        vecs.push_back('{2,  1, 1'b0, 1, 1'b1, 2});
        vecs.push_back('{65, 0, 1'b0, 0, 1'b0, 0});
        vecs.push_back('{0,  0, 1'b0, 0, 1'b1, 0});
        vecs.push_back('{64, 2, 1'b0, 0, 1'b1, 64});
        vecs.push_back('{1,  2, 1'b0, 0, 1'b1, 1});
`ifdef INSTR_LOADER_CHECKSUM_EN
        vecs.push_back('{1,  0, 1'b1, 2, 1'b0, 1});
        vecs.push_back('{1,  0, 1'b0, 2, 1'b1, 1});
`endif

        repeat (2) @(negedge Clk);
        check_reset_vals("rst");
        Clr_n = 1'b1;
        @(negedge Clk);

        foreach (vecs[i]) begin
            fill_words(vecs[i].n, vecs[i].wsel);
            pulse_start();
            build_frame(vecs[i].n, vecs[i].bad);
            run_frame(vecs[i].n, vecs[i].vmode, 8 * frame.size() + 50, cyc);
            final_check(vecs[i].exp_ok, vecs[i].exp_nw);
            if (vecs[i].n == DEPTH && wq.size() > 0)
                chk("last_addr", wq[wq.size()-1].addr, 4 * (DEPTH - 1));
            if (i == 0) cyc_first = cyc;
            if (i == 1) chk("toggle_slower", cyc > cyc_first, 1);
        end

        for (int it = 0; it < 10; it++) begin
            int n;
            int vm;
            bit bad;
            n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, DEPTH + 20))
                                              : int'($urandom_range(0, DEPTH));
            vm  = int'($urandom_range(0, 2));
            bad = 1'($urandom_range(0, 1));
            fill_words(n, 0);
            pulse_start();
            build_frame(n, bad);
            run_frame(n, vm, 8 * frame.size() + 50, cyc);
            final_check(model_ok(n, bad), (n <= DEPTH) ? n : 0);
        end

        // Reset in the middle of the second word; the first word stays written.
        fill_words(3, 0);
        wbuf[1] = 32'hA5C3_5A3C;
        pulse_start();
        build_frame(3, 1'b0);
        frame = frame[0:7];
        run_frame(3, 0, 100, cyc);
        chk("midload_writes", wq.size(), 1);
        Clr_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge Clk);
        Clr_n = 1'b1;
        fill_words(1, 0);
        build_frame(1, 1'b0);
        run_frame(1, 0, 100, cyc);
        final_check(1'b1, 1);

        // start and a valid byte together in DONE: the byte must be dropped.
        @(negedge Clk);
        start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
        chk("done_ready_low", bus.in_ready, 0);
        @(negedge Clk);
        start = 1'b0; bus.in_valid = 1'b0;
        chk("start_done", done, 0);
        chk("start_hold", pipe_hold, 1);
        fill_words(1, 0);
        wbuf[0] = 32'hCAFEF00D;
        build_frame(1, 1'b0);
        run_frame(1, 1, 100, cyc);
        final_check(1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "global timeout");
    end
endmodule
